line_buf_ctrl: RTL
==================

# line_buf_ctrl

Ping-pong line-buffer controller that schedules two MEM2048X24 macros for the HDL_final pixel pipeline. It writes the current active line into one bank while reading the previous line from the other, then swaps banks at every line end. It presents each current pixel together with the vertically adjacent pixel of the line above, aligned, to the UM/IM filter stages. It also owns the frame and line position counters and the frame-synchronous enable.

## Interface
Parameters:
- ADDR_W, 11, memory address width
- DATA_W, 24, pixel width (RGB888)
- MAX_PIX, 1920, maximum active pixels per line; must be ≤ 2**ADDR_W

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset: asynchronous assert, active-low
- en  in  1  line-buffer enable request, sampled only at frame start
- dpi_vs / dpi_hs / dpi_de  in  1 each  sync and data-enable inputs (DPi[26]/[25]/[24])
- dpi_rgb  in  DATA_W  input pixel (DPi[23:0])
- memN_cs, memN_web, memN_re  out  1 each  macro controls for N = 0, 1; web is active-low write
- memN_w_addr, memN_r_addr  out  ADDR_W  macro addresses
- memN_din  out  DATA_W  write data
- memN_dout  in  DATA_W  read data, valid 1 cycle after re
- out_vs, out_hs, out_de  out  1 each  syncs delayed to align with the pixel outputs
- cur_rgb  out  DATA_W  current pixel
- prev_rgb  out  DATA_W  same-column pixel from the previous line
- prev_valid  out  1  prev_rgb is meaningful
- h_pos, v_pos  out  ADDR_W  position of cur_rgb
- active  out  1  latched enable for the current frame

## Operation
- FSM states:
  - WAIT_VS: after reset; outputs pass through with prev_valid=0.
  - FIRST: first line of the frame.
  - RUN: second and later lines.
- Transitions:
  - Any state → FIRST on a dpi_vs rising edge. At the same time: h_cnt=0, v_cnt=0, wbank=0, active←en.
  - FIRST → RUN on the first dpi_de falling edge.
  - RUN stays in RUN until the next dpi_vs rising edge.
- Write bank on each dpi_de=1 cycle while active=1 and h_cnt<MAX_PIX:
  - mem[wbank]: cs=1, web=0, w_addr=h_cnt, din=dpi_rgb.
- Read bank: in RUN the same cycle drives mem[~wbank]: cs=1, re=1, r_addr=h_cnt. In FIRST there is no read.
- Idle macros get cs=0, web=1, re=0, and all address and data outputs driven to 0.
- h_cnt increments on each dpi_de cycle and saturates at MAX_PIX.
- Each dpi_de falling edge:
  - h_cnt=0
  - v_cnt+1, wrapping to 0 after 2**ADDR_W-1
  - wbank toggles
- prev_valid=1 only for out_de pixels in RUN with active=1 and h_pos<MAX_PIX.
- Where prev_valid=0, prev_rgb=0.
- If a line is longer than the previous one, the pixels beyond the previous length read stale bank contents. prev_valid stays 1; the downstream stage tolerates this.
- If dpi_vs rises in the same cycle as dpi_de=1, vsync wins: that pixel is not written or read, and the counters reset.
- If en changes mid-frame, nothing changes until the next dpi_vs rise.
- With active=0:
  - both macros have cs=0
  - cur_rgb=dpi_rgb delayed 1 cycle
  - prev_valid=0
  - counters still run

## Timing
- Fixed latency of 1 cycle from dpi_* to out_*, cur_rgb, prev_rgb, h_pos and v_pos. The memory read latency equals the input register delay.
- The bank swap occurs on the clock edge that samples the dpi_de falling edge, so no line-end gap is required.
- The controller supports back-to-back lines with a 1-cycle blanking gap.
- Reset values:
  - every output 0
  - memN_web=1
  - state WAIT_VS, wbank=0, active=0
- Reset asserted mid-line aborts immediately. The line stored in the bank is not cleared; prev_valid remains 0 until a full FIRST line has completed.

## Configuration
- LBUF_LINE_CHECK_EN defined adds output line_err (1 bit, registered):
  - pulses 1 cycle when a line exceeds MAX_PIX;
  - pulses 1 cycle when a RUN line length differs from the previous line length.
  - Previous line length is held in an ADDR_W+1-bit register.
- Undefined: port and logic absent; behaviour is otherwise identical.

## Structure
- Shared package hdl_pkg holds:
  - DPi bit-position constants (VS=26, HS=25, DE=24)
  - the pixel_t typedef (24-bit)
  - the FSM state enum
  - MAX_PIX_DEFAULT=1920
- One sub-module, lbuf_bank_mux: maps wbank plus the write and read requests onto the two macro port sets. Purely combinational, instantiated once.

## Test plan
- Reset then en=1, vs pulse, two 4-pixel lines of values 0x10..0x13 and 0x20..0x23 -> line 2 out: cur 0x20.., prev 0x10.., prev_valid=1; line 1 prev_valid=0.
- en=0 frame -> mem0_cs=mem1_cs=0 throughout, cur_rgb = input delayed 1, prev_rgb=0.
- en toggled 0→1 mid-frame -> active stays 0 until the next vs rise, then 1.
- vs rises together with de=1 on pixel 2 -> no write at that cycle, h_pos/v_pos restart at 0, state FIRST.
- 1925-pixel line -> writes stop at address 1919, h_cnt holds 1920; with LBUF_LINE_CHECK_EN, one line_err pulse.
- rst_n asserted mid-line 2 -> all outputs 0 that cycle, then the next frame's line 1 shows prev_valid=0.

Source files
------------

// File: rtl/hdl_pkg.sv
// Shared definitions for the HDL_final pixel pipeline: DPi bit positions,
// pixel type, line-buffer FSM states and the default line length.
package hdl_pkg;

  localparam int DPI_VS_BIT      = 26;
  localparam int DPI_HS_BIT      = 25;
  localparam int DPI_DE_BIT      = 24;
  localparam int MAX_PIX_DEFAULT = 1920;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_FIRST   = 2'd1,
    ST_RUN     = 2'd2
  } lbuf_state_t;

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Port set of one MEM2048X24 line-buffer macro; the controller is the master.
interface line_buf_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
);

  logic              cs;
  logic              web;
  logic              re;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output cs, web, re, w_addr, r_addr, din, input dout);
  modport slave  (input cs, web, re, w_addr, r_addr, din, output dout);

endinterface

// File: rtl/lbuf_bank_mux.sv
// Steers the write request to bank i_wbank and the read request to the other
// bank; a bank with no request is parked with cs=0, web=1 and zeroed buses.
module lbuf_bank_mux #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
) (
  input  logic                   i_wbank,
  input  logic                   i_wr_req,
  input  logic                   i_rd_req,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]      i_din,
  output logic [1:0]             o_cs,
  output logic [1:0]             o_web,
  output logic [1:0]             o_re,
  output logic [1:0][ADDR_W-1:0] o_w_addr,
  output logic [1:0][ADDR_W-1:0] o_r_addr,
  output logic [1:0][DATA_W-1:0] o_din
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic w_wr_sel;
      logic w_rd_sel;

      assign w_wr_sel     = i_wr_req && (i_wbank == 1'(gi));
      assign w_rd_sel     = i_rd_req && (i_wbank != 1'(gi));
      assign o_cs[gi]     = w_wr_sel || w_rd_sel;
      assign o_web[gi]    = ~w_wr_sel;
      assign o_re[gi]     = w_rd_sel;
      assign o_w_addr[gi] = w_wr_sel ? i_addr : '0;
      assign o_r_addr[gi] = w_rd_sel ? i_addr : '0;
      assign o_din[gi]    = w_wr_sel ? i_din  : '0;
    end
  endgenerate

endmodule

// File: rtl/line_buf_ctrl.sv
// Ping-pong line-buffer controller: writes the current line to one macro while
// reading the line above from the other. LBUF_LINE_CHECK_EN adds line_err.
module line_buf_ctrl
  import hdl_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 24,
  parameter int MAX_PIX = MAX_PIX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dpi_vs,
  input  logic              dpi_hs,
  input  logic              dpi_de,
  input  logic [DATA_W-1:0] dpi_rgb,
  line_buf_ctrl_if.master   mem0,
  line_buf_ctrl_if.master   mem1,
  output logic              out_vs,
  output logic              out_hs,
  output logic              out_de,
  output logic [DATA_W-1:0] cur_rgb,
  output logic [DATA_W-1:0] prev_rgb,
  output logic              prev_valid,
  output logic [ADDR_W-1:0] h_pos,
  output logic [ADDR_W-1:0] v_pos,
  output logic              active
`ifdef LBUF_LINE_CHECK_EN
  ,
  output logic              line_err
`endif
);

  localparam logic [ADDR_W:0] C_MAX = (ADDR_W+1)'(MAX_PIX);

  lbuf_state_t       r_state, w_state_next;
  logic              r_vs_d, r_hs_d, r_de_d;
  logic              r_wbank, r_rbank, r_active, r_prev_valid;
  logic [ADDR_W:0]   r_h_cnt;
  logic [ADDR_W-1:0] r_v_cnt, r_h_pos, r_v_pos;
  logic [DATA_W-1:0] r_rgb;

  logic w_vs_rise, w_de_fall, w_wr_req, w_rd_req;

  assign w_vs_rise = dpi_vs && !r_vs_d;
  assign w_de_fall = !dpi_de && r_de_d;
  // A vsync edge swallows any pixel presented in the same cycle.
  assign w_wr_req  = dpi_de && !w_vs_rise && r_active && (r_h_cnt < C_MAX);
  assign w_rd_req  = w_wr_req && (r_state == ST_RUN);

  always_comb begin
    w_state_next = r_state;
    if (w_vs_rise)
      w_state_next = ST_FIRST;
    else if (r_state == ST_FIRST && w_de_fall)
      w_state_next = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_WAIT_VS;
      r_vs_d       <= 1'b0;
      r_hs_d       <= 1'b0;
      r_de_d       <= 1'b0;
      r_rgb        <= '0;
      r_prev_valid <= 1'b0;
      r_rbank      <= 1'b0;
      r_h_pos      <= '0;
      r_v_pos      <= '0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_wbank      <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_vs_d       <= dpi_vs;
      r_hs_d       <= dpi_hs;
      r_de_d       <= dpi_de;
      r_rgb        <= dpi_rgb;
      r_prev_valid <= w_rd_req;
      r_rbank      <= ~r_wbank;
      r_h_pos      <= w_vs_rise ? '0 : r_h_cnt[ADDR_W-1:0];
      r_v_pos      <= w_vs_rise ? '0 : r_v_cnt;
      if (w_vs_rise) begin
        r_h_cnt  <= '0;
        r_v_cnt  <= '0;
        r_wbank  <= 1'b0;
        r_active <= en;
      end else if (w_de_fall) begin
        r_h_cnt  <= '0;
        r_v_cnt  <= r_v_cnt + ADDR_W'(1);
        r_wbank  <= ~r_wbank;
      end else if (dpi_de && r_h_cnt < C_MAX) begin
        r_h_cnt  <= r_h_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  logic [1:0]             w_cs, w_web, w_re;
  logic [1:0][ADDR_W-1:0] w_w_addr, w_r_addr;
  logic [1:0][DATA_W-1:0] w_din;

  lbuf_bank_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank_mux (
    .i_wbank  (r_wbank),
    .i_wr_req (w_wr_req),
    .i_rd_req (w_rd_req),
    .i_addr   (r_h_cnt[ADDR_W-1:0]),
    .i_din    (dpi_rgb),
    .o_cs     (w_cs),
    .o_web    (w_web),
    .o_re     (w_re),
    .o_w_addr (w_w_addr),
    .o_r_addr (w_r_addr),
    .o_din    (w_din)
  );

  assign mem0.cs     = w_cs[0];
  assign mem0.web    = w_web[0];
  assign mem0.re     = w_re[0];
  assign mem0.w_addr = w_w_addr[0];
  assign mem0.r_addr = w_r_addr[0];
  assign mem0.din    = w_din[0];
  assign mem1.cs     = w_cs[1];
  assign mem1.web    = w_web[1];
  assign mem1.re     = w_re[1];
  assign mem1.w_addr = w_w_addr[1];
  assign mem1.r_addr = w_r_addr[1];
  assign mem1.din    = w_din[1];

  // Macro read data arrives one cycle after re, in step with the registered pixel.
  assign prev_rgb   = !r_prev_valid ? '0 : (r_rbank ? mem1.dout : mem0.dout);
  assign prev_valid = r_prev_valid;
  assign out_vs     = r_vs_d;
  assign out_hs     = r_hs_d;
  assign out_de     = r_de_d;
  assign cur_rgb    = r_rgb;
  assign h_pos      = r_h_pos;
  assign v_pos      = r_v_pos;
  assign active     = r_active;

`ifdef LBUF_LINE_CHECK_EN
  logic            r_ovf, r_line_err;
  logic [ADDR_W:0] r_prev_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_line_err <= 1'b0;
      r_prev_len <= '0;
    end else begin
      r_line_err <= 1'b0;
      if (w_vs_rise) begin
        r_ovf <= 1'b0;
      end else if (w_de_fall) begin
        r_line_err <= r_ovf || (r_state == ST_RUN && r_h_cnt != r_prev_len);
        r_prev_len <= r_h_cnt;
        r_ovf      <= 1'b0;
      end else if (dpi_de && r_h_cnt == C_MAX) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign line_err = r_line_err;
`endif

endmodule
